// File: rtl/adc_pkg.sv
// Shared definitions for the dual-channel ADC sample filter: sample width,
// control-FSM state encoding and the min/max tracker reset values.
package adc_pkg;

    localparam int ADC_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    localparam logic [ADC_W-1:0] MIN_RST = 12'hFFF;
    localparam logic [ADC_W-1:0] MAX_RST = 12'h000;

endpackage

// File: rtl/adc_chan_avg.sv
// One ADC channel: block accumulator, truncating average and hysteretic
// threshold alarm. Sequencing (load/add/last) is driven by the top-level FSM.
module adc_chan_avg
    import adc_pkg::*;
#(
    parameter int               AVG_LOG2 = 3,
    parameter logic [ADC_W-1:0] THRESH   = 12'd2048,
    parameter logic [ADC_W-1:0] HYST     = 12'd64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             add,
    input  logic             last,
    input  logic [ADC_W-1:0] sample,
    output logic [ADC_W-1:0] avg,
    output logic             alarm
);

    localparam int               ACC_W   = ADC_W + AVG_LOG2;
    localparam logic [ADC_W-1:0] CLR_LVL = THRESH - HYST;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ADC_W-1:0] avg_next;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_next = acc;
        if (load)
            acc_next = ACC_W'(sample);
        else if (add)
            acc_next = acc + ACC_W'(sample);
        avg_next = acc_next[ACC_W-1 -: ADC_W];
    end

    // Average and alarm are captured on the edge that accepts the final
    // sample, so they are already visible during the PUBLISH cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            avg   <= '0;
            alarm <= 1'b0;
        end else begin
            if (clear)
                acc <= '0;
            else if (load || add)
                acc <= acc_next;

            if (last) begin
                avg <= avg_next;
                if (avg_next >= THRESH)
                    alarm <= 1'b1;
                else if (avg_next < CLR_LVL)
                    alarm <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_sample_filter.sv
// Dual-channel block-averaging filter for ltc2308 readings with alarms and
// sample counter. Define ADC_MINMAX_EN to build the per-channel min/max trackers.
module adc_sample_filter
    import adc_pkg::*;
#(
    parameter int               AVG_LOG2 = 3,
    parameter logic [ADC_W-1:0] THRESH   = 12'd2048,
    parameter logic [ADC_W-1:0] HYST     = 12'd64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] reading0,
    input  logic [ADC_W-1:0] reading1,
    input  logic             clear,
    output logic             avg_valid,
    output logic [31:0]      s1,
    output logic [1:0]       alarm,
    output logic [15:0]      sample_count,
    output logic [47:0]      minmax
);

    localparam int             CNT_W    = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             start_blk;
    logic             add_smp;
    logic             last_smp;
    logic [ADC_W-1:0] avg0;
    logic [ADC_W-1:0] avg1;

    // clear wins over a coincident strobe: that sample is neither used nor counted.
    assign accept    = sample_valid && !clear;
    assign start_blk = accept && (state != ACCUM);
    assign add_smp   = accept && (state == ACCUM);
    assign last_smp  = add_smp && (count == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = ACCUM;
                ACCUM:   if (last_smp) state_next = PUBLISH;
                PUBLISH: state_next = accept ? ACCUM : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        avg_valid = (state == PUBLISH) && !clear;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            sample_count <= '0;
        end else begin
            if (clear)
                count <= '0;
            else if (start_blk)
                count <= CNT_W'(1);
            else if (add_smp)
                count <= count + CNT_W'(1);
            else if (state != ACCUM)
                count <= '0;

            if (accept)
                sample_count <= sample_count + 16'd1;
        end
    end

    adc_chan_avg #(.AVG_LOG2(AVG_LOG2), .THRESH(THRESH), .HYST(HYST)) u_chan0 (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .load   (start_blk),
        .add    (add_smp),
        .last   (last_smp),
        .sample (reading0),
        .avg    (avg0),
        .alarm  (alarm[0])
    );

    adc_chan_avg #(.AVG_LOG2(AVG_LOG2), .THRESH(THRESH), .HYST(HYST)) u_chan1 (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .load   (start_blk),
        .add    (add_smp),
        .last   (last_smp),
        .sample (reading1),
        .avg    (avg1),
        .alarm  (alarm[1])
    );

    assign s1 = {4'b0, avg1, 4'b0, avg0};

`ifdef ADC_MINMAX_EN
    logic [ADC_W-1:0] min0, max0, min1, max1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            min0 <= MIN_RST;
            max0 <= MAX_RST;
            min1 <= MIN_RST;
            max1 <= MAX_RST;
        end else if (accept) begin
            if (reading0 < min0) min0 <= reading0;
            if (reading0 > max0) max0 <= reading0;
            if (reading1 < min1) min1 <= reading1;
            if (reading1 > max1) max1 <= reading1;
        end
    end

    assign minmax = {max1, min1, max0, min0};
`else
    assign minmax = 48'h0;
`endif

endmodule

// File: tb/tb_adc_sample_filter.sv
// Self-checking bench for adc_sample_filter: directed scenarios plus random
// traffic against a queue-based block-average model. Honours ADC_MINMAX_EN.
module tb_adc_sample_filter;

    localparam int          AVG_LOG2 = 3;
    localparam int          BLK      = 1 << AVG_LOG2;
    localparam int          THRESH   = 2048;
    localparam int          HYST     = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] reading0;
    logic [11:0] reading1;
    logic        clear;
    logic        avg_valid;
    logic [31:0] s1;
    logic [1:0]  alarm;
    logic [15:0] sample_count;
    logic [47:0] minmax;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int          q0[$];
    int          q1[$];
    logic        exp_av;
    logic [31:0] exp_s1;
    logic [1:0]  exp_alarm;
    logic [15:0] exp_cnt;
    int          mn0, mx0, mn1, mx1;

    adc_sample_filter #(.AVG_LOG2(AVG_LOG2), .THRESH(12'd2048), .HYST(12'd64)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .reading0     (reading0),
        .reading1     (reading1),
        .clear        (clear),
        .avg_valid    (avg_valid),
        .s1           (s1),
        .alarm        (alarm),
        .sample_count (sample_count),
        .minmax       (minmax)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_minmax_reset();
        mn0 = 4095; mx0 = 0; mn1 = 4095; mx1 = 0;
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        exp_av = 1'b0; exp_s1 = 32'h0; exp_alarm = 2'b00; exp_cnt = 16'h0;
        model_minmax_reset();
    endtask

    function automatic logic next_alarm(input logic cur, input int avg);
        if (avg >= THRESH) return 1'b1;
        if (avg < THRESH - HYST) return 1'b0;
        return cur;
    endfunction

    task automatic model_step(input logic v, input int a, input int b, input logic c);
        int s0, s1m, av0, av1;
        exp_av = 1'b0;
        if (c) begin
            q0.delete(); q1.delete();
            model_minmax_reset();
        end else if (v) begin
            exp_cnt = exp_cnt + 16'd1;
            q0.push_back(a); q1.push_back(b);
            if (a < mn0) mn0 = a;
            if (a > mx0) mx0 = a;
            if (b < mn1) mn1 = b;
            if (b > mx1) mx1 = b;
            if (q0.size() == BLK) begin
                s0 = 0; s1m = 0;
                foreach (q0[i]) s0 += q0[i];
                foreach (q1[i]) s1m += q1[i];
                av0 = s0 / BLK;
                av1 = s1m / BLK;
                exp_s1 = {4'h0, 12'(av1), 4'h0, 12'(av0)};
                exp_alarm = {next_alarm(exp_alarm[1], av1), next_alarm(exp_alarm[0], av0)};
                exp_av = 1'b1;
                q0.delete(); q1.delete();
            end
        end
    endtask

    task automatic check_all();
        check("avg_valid", {63'h0, avg_valid}, {63'h0, exp_av});
        check("s1", {32'h0, s1}, {32'h0, exp_s1});
        check("alarm", {62'h0, alarm}, {62'h0, exp_alarm});
        check("sample_count", {48'h0, sample_count}, {48'h0, exp_cnt});
`ifdef ADC_MINMAX_EN
        check("minmax", {16'h0, minmax}, {16'h0, 12'(mx1), 12'(mn1), 12'(mx0), 12'(mn0)});
`else
        check("minmax", {16'h0, minmax}, 64'h0);
`endif
    endtask

    // Apply inputs for one cycle, then check outputs 1 time unit after the edge.
    task automatic drive(input logic v, input int a, input int b, input logic c);
        sample_valid = v; reading0 = 12'(a); reading1 = 12'(b); clear = c;
        @(posedge clk); #1;
        sample_valid = 1'b0; clear = 1'b0;
        model_step(v, a, b, c);
        check_all();
    endtask

    initial begin
        logic [15:0] cnt_base;

        reset = 1'b1; sample_valid = 1'b0; reading0 = '0; reading1 = '0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_all();

        // Min/max tracking, then clear restores tracker reset values
        drive(1, 5, 300, 0);
        drive(1, 900, 10, 0);
        drive(1, 17, 4000, 0);
`ifdef ADC_MINMAX_EN
        check("min0", {52'h0, minmax[11:0]}, 64'd5);
        check("max0", {52'h0, minmax[23:12]}, 64'd900);
`else
        check("minmax_off", {16'h0, minmax}, 64'h0);
`endif
        drive(0, 0, 0, 1);

        // Basic block: 100 / 4095
        for (int i = 0; i < BLK; i++) drive(1, 100, 4095, 0);
        check("s1_basic", {32'h0, s1}, 64'h0FFF_0064);
        check("alarm_basic", {62'h0, alarm}, 64'b10);
        drive(0, 0, 0, 0);
        check("avg_valid_single", {63'h0, avg_valid}, 64'h0);

        // Hysteresis on channel 0: set, hold, clear
        for (int i = 0; i < BLK; i++) drive(1, 2100, 0, 0);
        check("alarm0_set", {63'h0, alarm[0]}, 64'h1);
        for (int i = 0; i < BLK; i++) drive(1, 2000, 0, 0);
        check("alarm0_hold", {63'h0, alarm[0]}, 64'h1);
        for (int i = 0; i < BLK; i++) drive(1, 1983, 0, 0);
        check("alarm0_clear", {63'h0, alarm[0]}, 64'h0);

        // Back-to-back blocks: first strobe of block 2 lands in PUBLISH
        for (int i = 0; i < BLK; i++) drive(1, 8, 8, 0);
        for (int i = 0; i < BLK; i++) drive(1, 8, 8, 0);
        check("avg0_b2b", {52'h0, s1[11:0]}, 64'd8);
        check("avg_valid_b2b", {63'h0, avg_valid}, 64'h1);

        // clear during the PUBLISH cycle suppresses avg_valid
        clear = 1'b1; #1;
        check("avg_valid_clear_publish", {63'h0, avg_valid}, 64'h0);
        @(posedge clk); #1;
        clear = 1'b0;
        model_step(0, 0, 0, 1);
        check_all();

        // clear coincident with 4th strobe, then one full block
        cnt_base = exp_cnt;
        for (int i = 0; i < 3; i++) drive(1, 1000, 1000, 0);
        drive(1, 1000, 1000, 1);
        for (int i = 0; i < BLK; i++) drive(1, 3000, 50, 0);
        check("cnt_after_clear", {48'h0, sample_count}, {48'h0, cnt_base + 16'd11});
        check("s1_after_clear", {32'h0, s1}, 64'h0032_0BB8);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                  ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset mid-block discards the partial block
        drive(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, 3500, 3500, 0);
        reset = 1'b1; #1;
        model_reset();
        check_all();
        @(posedge clk); #1 reset = 1'b0;
        check_all();
        for (int i = 0; i < BLK - 1; i++) drive(1, 40, 2500, 0);
        check("no_early_pub", {63'h0, avg_valid}, 64'h0);
        drive(1, 40, 2500, 0);
        check("pub_after_reset", {63'h0, avg_valid}, 64'h1);
        check("s1_after_reset", {32'h0, s1}, 64'h09C4_0028);

        // sample_count wrap 16'hFFFF -> 0
        while (exp_cnt != 16'hFFFF)
            drive(1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 0);
        drive(1, 7, 7, 0);
        check("cnt_wrap", {48'h0, sample_count}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
